// File: rtl/arb8_pkg.sv
// Shared types and sizes for the 8-requester arbiter.
package arb8_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [N_REQ-1:0] req_t;

endpackage

// File: rtl/pri_pick8.sv
// Combinational rotated priority picker: first set request scanning iPtr, iPtr+1, ... mod 8.
// With ARB_FIXED_PRI_EN defined, iPtr is ignored and requester 7 is highest, 0 lowest.
module pri_pick8
  import arb8_pkg::*;
(
  input  logic [N_REQ-1:0] iReq,
  input  logic [ID_W-1:0]  iPtr,
  output logic [ID_W-1:0]  oId,
  output logic             oAny
);

  id_t scan_idx;

`ifdef ARB_FIXED_PRI_EN
  logic unused_ptr;
  assign unused_ptr = ^iPtr;
`endif

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a latch behind.
    oId      = '0;
    oAny     = 1'b0;
    scan_idx = '0;
    // Walk from lowest priority to highest; the last hit is the winner.
    for (int i = N_REQ - 1; i >= 0; i--) begin
`ifdef ARB_FIXED_PRI_EN
      scan_idx = ID_W'(N_REQ - 1 - i);
`else
      scan_idx = iPtr + ID_W'(i);
`endif
      if (iReq[scan_idx]) begin
        oId  = scan_idx;
        oAny = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter8_rr.sv
// Registered 8-requester arbiter: round-robin with optional hold timeout.
// Define ARB_FIXED_PRI_EN for fixed priority (7 highest); the pointer is then held at 0.
module arbiter8_rr
  import arb8_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEI,
  input  logic [N_REQ-1:0] iReq,
  output logic [N_REQ-1:0] oGnt,
  output logic [ID_W-1:0]  oGntId,
  output logic             oValid,
  output logic             oEO
);

  localparam bit               HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(HOLD_MAX - 1) : '0;

  arb_state_t       state_q, state_d;
  req_t             gnt_q, gnt_d;
  id_t              gnt_id_q, gnt_id_d;
  logic             valid_q, valid_d;
  logic             eo_q, eo_d;
  id_t              ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  id_t  pick_id;
  logic pick_any;
  logic req_drop;
  logic timeout;
  id_t  next_ptr;

  pri_pick8 u_pick (
    .iReq (iReq),
    .iPtr (ptr_q),
    .oId  (pick_id),
    .oAny (pick_any)
  );

  assign req_drop = ~iReq[gnt_id_q];
  assign timeout  = HOLD_EN && (hold_cnt_q == HOLD_LAST);

`ifdef ARB_FIXED_PRI_EN
  assign next_ptr = '0;
`else
  assign next_ptr = gnt_id_q + ID_W'(1);
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (!iEI && pick_any) begin
          state_d    = GRANT;
          gnt_d      = N_REQ'(1) << pick_id;
          gnt_id_d   = pick_id;
          valid_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
        // Release always takes a full IDLE cycle; gnt_id keeps the last owner.
        if (req_drop || timeout || iEI) begin
          state_d    = IDLE;
          gnt_d      = '0;
          valid_d    = 1'b0;
          hold_cnt_d = '0;
          if (req_drop || timeout) ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase

    eo_d = (state_d == IDLE) && !iEI && (iReq == '0);
  end

  always_ff @(posedge iClk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (iRst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      valid_q    <= 1'b0;
      eo_q       <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      valid_q    <= valid_d;
      eo_q       <= eo_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign oGnt   = gnt_q;
  assign oGntId = gnt_id_q;
  assign oValid = valid_q;
  assign oEO    = eo_q;

endmodule

// File: tb/tb_arbiter8_rr.sv
// Directed bench for arbiter8_rr built with HOLD_MAX=4 so the timeout is reachable quickly.
module tb_arbiter8_rr;

  logic       clk;
  logic       rst;
  logic       ei;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       valid;
  logic       eo;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  arbiter8_rr #(.HOLD_MAX(4), .CNT_W(3)) dut (
    .iClk   (clk),
    .iRst   (rst),
    .iEI    (ei),
    .iReq   (req),
    .oGnt   (gnt),
    .oGntId (gnt_id),
    .oValid (valid),
    .oEO    (eo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants every cycle once reset has been applied.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(gnt) || (valid && gnt !== (8'h01 << gnt_id)) || (!valid && gnt !== 8'h00)) begin
        errors++;
        $display("FAIL invariant: gnt=%h id=%0d valid=%b, required one-hot gnt matching id when valid, zero otherwise",
                 gnt, gnt_id, valid);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ei  = 1'b0;
    req = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    checks++;
    if (gnt !== 8'h00 || gnt_id !== 3'd0 || valid !== 1'b0 || eo !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%h id=%0d valid=%b eo=%b, required 00 0 0 0", gnt, gnt_id, valid, eo);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (gnt !== 8'h00 || valid !== 1'b0 || eo !== 1'b1) begin
        errors++;
        $display("FAIL idle_eo cycle %0d: gnt=%h valid=%b eo=%b, required 00 0 1", c, gnt, valid, eo);
      end
    end
  endtask

  task automatic test_rr_basic();
    do_reset();
    req = 8'h81;
    tick();
    checks++;
    if (gnt !== 8'h01 || gnt_id !== 3'd0 || valid !== 1'b1 || eo !== 1'b0) begin
      errors++;
      $display("FAIL rr_first: gnt=%h id=%0d valid=%b eo=%b, required 01 0 1 0", gnt, gnt_id, valid, eo);
    end
    req = 8'h80;
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_id !== 3'd0 || valid !== 1'b0 || eo !== 1'b0) begin
      errors++;
      $display("FAIL rr_release0: gnt=%h id=%0d valid=%b eo=%b, required 00 0 0 0", gnt, gnt_id, valid, eo);
    end
    tick();
    checks++;
    if (gnt !== 8'h80 || gnt_id !== 3'd7 || valid !== 1'b1) begin
      errors++;
      $display("FAIL rr_second: gnt=%h id=%0d valid=%b, required 80 7 1", gnt, gnt_id, valid);
    end
    req = 8'h00;
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_id !== 3'd7 || valid !== 1'b0 || eo !== 1'b1) begin
      errors++;
      $display("FAIL rr_release7: gnt=%h id=%0d valid=%b eo=%b, required 00 7 0 1", gnt, gnt_id, valid, eo);
    end
    // Pointer wrapped from 7 to 0, so requester 0 beats requester 7 again.
    req = 8'h81;
    tick();
    checks++;
    if (gnt !== 8'h01 || gnt_id !== 3'd0) begin
      errors++;
      $display("FAIL rr_wrap: gnt=%h id=%0d, required 01 0", gnt, gnt_id);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_timeout();
    logic [7:0] exp_gnt;
    do_reset();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      exp_gnt = 8'h01 << (k % 8);
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (gnt !== exp_gnt || gnt_id !== 3'(k % 8) || valid !== 1'b1) begin
          errors++;
          $display("FAIL timeout_hold k=%0d c=%0d: gnt=%h id=%0d valid=%b, required %h %0d 1",
                   k, c, gnt, gnt_id, valid, exp_gnt, k % 8);
        end
        tick();
      end
      checks++;
      if (gnt !== 8'h00 || valid !== 1'b0 || eo !== 1'b0) begin
        errors++;
        $display("FAIL timeout_gap k=%0d: gnt=%h valid=%b eo=%b, required 00 0 0", k, gnt, valid, eo);
      end
      tick();
    end
    req = 8'h00;
    tick(2);
  endtask

  task automatic test_enable();
    do_reset();
    req = 8'h04;
    tick();
    req = 8'h00;
    tick();
    // ptr is now 3; requester 3 wins over 4.
    req = 8'h18;
    tick();
    checks++;
    if (gnt !== 8'h08 || gnt_id !== 3'd3) begin
      errors++;
      $display("FAIL en_grant3: gnt=%h id=%0d, required 08 3", gnt, gnt_id);
    end
    ei = 1'b1;
    tick();
    checks++;
    if (gnt !== 8'h00 || valid !== 1'b0 || eo !== 1'b0 || gnt_id !== 3'd3) begin
      errors++;
      $display("FAIL en_off: gnt=%h id=%0d valid=%b eo=%b, required 00 3 0 0", gnt, gnt_id, valid, eo);
    end
    tick();
    checks++;
    if (gnt !== 8'h00 || valid !== 1'b0 || eo !== 1'b0) begin
      errors++;
      $display("FAIL en_idle_blocked: gnt=%h valid=%b eo=%b, required 00 0 0", gnt, valid, eo);
    end
    ei = 1'b0;
    tick();
    checks++;
    if (gnt !== 8'h08 || gnt_id !== 3'd3 || valid !== 1'b1) begin
      errors++;
      $display("FAIL en_regrant3: gnt=%h id=%0d valid=%b, required 08 3 1", gnt, gnt_id, valid);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_rst_mid();
    do_reset();
    req = 8'h01;
    tick();
    req = 8'h00;
    tick();
    req = 8'h21;
    tick();
    checks++;
    if (gnt !== 8'h20 || gnt_id !== 3'd5) begin
      errors++;
      $display("FAIL rst_mid_grant5: gnt=%h id=%0d, required 20 5", gnt, gnt_id);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (gnt !== 8'h00 || gnt_id !== 3'd0 || valid !== 1'b0 || eo !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_cleared: gnt=%h id=%0d valid=%b eo=%b, required 00 0 0 0", gnt, gnt_id, valid, eo);
    end
    tick();
    checks++;
    if (gnt !== 8'h01 || gnt_id !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_regrant0: gnt=%h id=%0d, required 01 0", gnt, gnt_id);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 8'h01;
    tick();
    // Owner drops while another requests: release first, no direct hand-over.
    req = 8'h02;
    tick();
    checks++;
    if (gnt !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: gnt=%h valid=%b, required 00 0", gnt, valid);
    end
    tick();
    checks++;
    if (gnt !== 8'h02 || gnt_id !== 3'd1) begin
      errors++;
      $display("FAIL b2b_next: gnt=%h id=%0d, required 02 1", gnt, gnt_id);
    end
    // A non-owner request during the grant is ignored.
    req = 8'h06;
    tick();
    checks++;
    if (gnt !== 8'h02 || gnt_id !== 3'd1) begin
      errors++;
      $display("FAIL b2b_ignore: gnt=%h id=%0d, required 02 1", gnt, gnt_id);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_fixed_pri();
    do_reset();
    req = 8'h2A;
    tick();
    checks++;
    if (gnt !== 8'h20 || gnt_id !== 3'd5) begin
      errors++;
      $display("FAIL fixed_5: gnt=%h id=%0d, required 20 5", gnt, gnt_id);
    end
    req = 8'h0A;
    tick(2);
    checks++;
    if (gnt !== 8'h08 || gnt_id !== 3'd3) begin
      errors++;
      $display("FAIL fixed_3: gnt=%h id=%0d, required 08 3", gnt, gnt_id);
    end
    req = 8'h02;
    tick(2);
    checks++;
    if (gnt !== 8'h02 || gnt_id !== 3'd1) begin
      errors++;
      $display("FAIL fixed_1: gnt=%h id=%0d, required 02 1", gnt, gnt_id);
    end
    req = 8'h00;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    ei  = 1'b0;
    req = 8'h00;
    test_reset();
`ifdef ARB_FIXED_PRI_EN
    test_fixed_pri();
`else
    test_rr_basic();
    test_timeout();
    test_enable();
    test_rst_mid();
    test_back_to_back();
`endif
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
